fetch_unit: RTL and testbench

Instruction fetch stage and IF/ID pipeline register, directly upstream of `control_unit`.
- Keeps the PC and issues one instruction-memory request at a time.
- Holds each fetched word for decode and slices it into `instruction_type`/`func`.
- Redirects the PC using the branch flags that `control_unit` produced for the instruction now in EX (`Brinco`, `Equal`, `LessEqual`, `GreaterEqual`) and the ALU subtraction flags.

---
 rtl/fetch_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_fetch_unit.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage plus IF/ID pipeline register. Keeps the
//            PC, issues one instruction-memory request at a time, holds the
//            fetched word for decode and redirects on taken branches resolved
//            in EX.
// Ports    : clk/rst           - rising-edge clock, synchronous active-high reset
//            imem_*            - single-outstanding request/response memory port
//            stall             - hazard unit freeze of IF/ID
//            ex_*              - branch flags, ALU flags and target of EX instr
//            if_valid/if_instr/if_pc - IF/ID register contents
//            instruction_type/func   - decode fields sliced from if_instr
//            flush             - one-cycle pulse killing the younger ID/EX instr
//            perf_fetched/perf_redirects - optional event counters
// Options  : define FETCH_PERF_CNT_EN to add the performance counter outputs.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               ex_brinco,
    input  logic               ex_equal,
    input  logic               ex_leq,
    input  logic               ex_geq,
    input  logic               ex_zero,
    input  logic               ex_neg,
    input  logic [ADDR_W-1:0]  ex_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [1:0]         instruction_type,
    output logic [4:0]         func,
    output logic               flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_redirects
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] C_PC_STEP = ADDR_W'(4);

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_discard;
    logic                w_discard_next;

    logic                r_skid_valid;
    logic [INSTR_W-1:0]  r_skid_instr;
    logic [ADDR_W-1:0]   r_skid_pc;

    logic                r_if_valid;
    logic [INSTR_W-1:0]  r_if_instr;
    logic [ADDR_W-1:0]   r_if_pc;
    logic                r_flush;

    logic                w_taken;
    logic                w_req;
    logic                w_accept;
    logic                w_inflight;
    logic                w_load_rsp;
    logic                w_load_skid;
    logic                w_capture_skid;

    // ------------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_taken = ex_brinco
                | (ex_equal & ex_zero)
                | (ex_leq   & (ex_zero | ex_neg))
                | (ex_geq   & ~ex_neg);

        // A pending discard blocks new requests so that at most one response
        // is ever in flight, even across a redirect.
        w_req    = (r_state == ST_REQ) && !r_discard;
        w_accept = w_req && imem_ready;

        // A response is still owed after this cycle if one was already being
        // discarded, if WAIT has not seen its data yet, or if a request is
        // accepted right now. HOLD has already received its response.
        w_inflight = (r_discard && !imem_rvalid)
                   || ((r_state == ST_WAIT) && !imem_rvalid)
                   || w_accept;

        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_discard_next = r_discard && !imem_rvalid;
        w_load_rsp     = 1'b0;
        w_load_skid    = 1'b0;
        w_capture_skid = 1'b0;

        if (w_taken) begin
            // Redirect outranks stall and any arriving data.
            w_state_next   = ST_REQ;
            w_pc_next      = ex_target;
            w_discard_next = w_inflight;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_next = ST_REQ;
                end
                ST_REQ: begin
                    if (w_accept) begin
                        w_pc_next    = r_pc + C_PC_STEP;
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (stall) begin
                            w_capture_skid = 1'b1;
                            w_state_next   = ST_HOLD;
                        end else begin
                            w_load_rsp   = 1'b1;
                            w_state_next = ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_load_skid  = r_skid_valid;
                        w_state_next = ST_REQ;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State, PC and discard registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            // A response owed at the time of reset must not reach IF/ID.
            r_discard <= w_inflight;
        end else begin
            r_state   <= w_state_next;
            r_pc      <= w_pc_next;
            r_discard <= w_discard_next;
        end
    end

    // ------------------------------------------------------------------------
    // Request address, skid buffer and IF/ID register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_addr   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
            r_if_valid   <= 1'b0;
            r_if_instr   <= '0;
            r_if_pc      <= '0;
            r_flush      <= 1'b0;
        end else begin
            r_flush <= w_taken;
            if (w_accept) begin
                r_req_addr <= r_pc;
            end
            if (w_taken) begin
                r_if_valid   <= 1'b0;
                r_skid_valid <= 1'b0;
            end else begin
                if (w_capture_skid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_instr <= imem_rdata;
                    r_skid_pc    <= r_req_addr;
                end
                if (w_load_rsp) begin
                    r_if_valid <= 1'b1;
                    r_if_instr <= imem_rdata;
                    r_if_pc    <= r_req_addr;
                end else if (w_load_skid) begin
                    r_if_valid   <= 1'b1;
                    r_if_instr   <= r_skid_instr;
                    r_if_pc      <= r_skid_pc;
                    r_skid_valid <= 1'b0;
                end else if (!stall) begin
                    r_if_valid <= 1'b0;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_redirects;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched   <= '0;
            r_perf_redirects <= '0;
        end else begin
            if (!w_taken && (w_load_rsp || w_load_skid)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (w_taken) begin
                r_perf_redirects <= r_perf_redirects + 32'd1;
            end
        end
    end

    assign perf_fetched   = r_perf_fetched;
    assign perf_redirects = r_perf_redirects;
`endif

    assign imem_req         = w_req;
    assign imem_addr        = r_pc;
    assign if_valid         = r_if_valid;
    assign if_instr         = r_if_instr;
    assign if_pc            = r_if_pc;
    assign instruction_type = r_if_instr[31:30];
    assign func             = r_if_instr[29:25];
    assign flush            = r_flush;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A memory model answers
//            requests and queues the expected IF/ID contents; a scoreboard
//            pops and compares on every IF/ID load. Scenario tasks add
//            directed checks on request, redirect and stall behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0100;
    localparam logic [31:0] DEAD_ADDR = 32'h0000_0104;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        ex_brinco, ex_equal, ex_leq, ex_geq, ex_zero, ex_neg;
    logic [31:0] ex_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [1:0]  instruction_type;
    logic [4:0]  func;
    logic        flush;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    int   total;
    int   bad;
    exp_t exp_q[$];

    // memory model controls
    int          hold_ready;
    int          rsp_extra;
    logic [31:0] rsp_xor;
    logic        rsp_pend;
    int          rsp_delay;
    logic [31:0] rsp_data;
    logic        stall_q;

    fetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .stall            (stall),
        .ex_brinco        (ex_brinco),
        .ex_equal         (ex_equal),
        .ex_leq           (ex_leq),
        .ex_geq           (ex_geq),
        .ex_zero          (ex_zero),
        .ex_neg           (ex_neg),
        .ex_target        (ex_target),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .instruction_type (instruction_type),
        .func             (func),
        .flush            (flush)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_redirects   (perf_redirects)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == DEAD_ADDR) return 32'hDEAD_BEEF;
        return a ^ 32'h1357_0000;
    endfunction

    // Memory: accepts a request unless hold_ready is counting down, answers
    // rsp_extra cycles after the accept cycle's successor.
    initial begin : mem_model
        exp_t e;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        rsp_pend    = 1'b0;
        rsp_delay   = 0;
        rsp_data    = '0;
        forever begin
            @(negedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (rsp_pend) begin
                if (rsp_delay == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = rsp_data;
                    rsp_pend    = 1'b0;
                end else begin
                    rsp_delay--;
                end
            end
            imem_ready = 1'b0;
            if (imem_req) begin
                if (hold_ready > 0) begin
                    hold_ready--;
                end else begin
                    imem_ready = 1'b1;
                    rsp_pend   = 1'b1;
                    rsp_delay  = rsp_extra;
                    rsp_data   = mem_data(imem_addr) ^ rsp_xor;
                    e.pc       = imem_addr;
                    e.instr    = mem_data(imem_addr);
                    exp_q.push_back(e);
                end
            end
        end
    end

    always @(posedge clk) stall_q <= stall;

    // Every IF/ID load (if_valid after an unstalled edge) must match the
    // oldest expected fetch.
    initial begin : scoreboard
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_valid === 1'b1 && stall_q === 1'b0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_load: unexpected load pc=%h instr=%h, nothing expected", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc !== e.pc || if_instr !== e.instr) begin
                        bad++;
                        $display("FAIL sb_load: got pc=%h instr=%h expected pc=%h instr=%h",
                                 if_pc, if_instr, e.pc, e.instr);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_ex();
        ex_brinco = 1'b0; ex_equal = 1'b0; ex_leq = 1'b0;
        ex_geq    = 1'b0; ex_zero  = 1'b0; ex_neg = 1'b0;
        ex_target = '0;
    endtask

    // Ends on the negedge of the first cycle with a request visible.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; hold_ready = 0; rsp_extra = 0; rsp_xor = '0;
        clear_ex();
        repeat (2) @(negedge clk);
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for an accepted request; returns its address and the
    // number of cycles skipped before it. Leaves time at the next negedge.
    task automatic wait_accept(output logic [31:0] a, output int cycles);
        cycles = 0;
        #2;
        while (!(imem_req && imem_ready) && cycles < 50) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        a = imem_addr;
        if (cycles >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: got no accepted request expected one within 50 cycles");
        end
        @(negedge clk);
    endtask

    task automatic wait_if_valid(input string name, input logic [31:0] pc_exp);
        bit found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            #2;
            if (if_valid === 1'b1) found = 1'b1;
        end
        total++;
        if (!found || if_pc !== pc_exp) begin
            bad++;
            $display("FAIL %s: got valid=%0b if_pc=%h expected valid=1 if_pc=%h", name, found, if_pc, pc_exp);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RESET_PC); end
        total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h expected 0", if_instr); end
        total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h expected 0", if_pc); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b expected 0", flush); end
        rst = 1'b0;
        @(negedge clk);
        #2;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++;
            $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        int          gap;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_accept(a, gap);
            total++;
            if (a !== RESET_PC + 32'(4 * i)) begin
                bad++; $display("FAIL seq_addr%0d: got %h expected %h", i, a, RESET_PC + 32'(4 * i));
            end
            if (i > 0) begin
                total++;
                if (gap !== 1) begin bad++; $display("FAIL seq_gap%0d: got %0d expected 1", i, gap); end
            end
        end
    endtask

    task automatic test_ready_low();
        logic [31:0] a;
        int          gap;
        do_reset();
        wait_accept(a, gap);
        hold_ready = 3;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            #2;
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h104 || imem_ready !== (k == 3)) begin
                bad++;
                $display("FAIL ready_low%0d: got req=%b addr=%h ready=%b expected req=1 addr=00000104 ready=%0b",
                         k, imem_req, imem_addr, imem_ready, (k == 3));
            end
            @(negedge clk);
        end
        wait_accept(a, gap);
        total++;
        if (a !== 32'h108) begin bad++; $display("FAIL ready_next: got %h expected 00000108", a); end
    endtask

    task automatic test_stall_skid();
        do_reset();
        repeat (2) @(negedge clk);
        stall = 1'b1;
        #2;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== DEAD_ADDR || if_instr !== mem_data(RESET_PC)) begin
            bad++;
            $display("FAIL stall_pre: got req=%b addr=%h instr=%h expected req=1 addr=%h instr=%h",
                     imem_req, imem_addr, if_instr, DEAD_ADDR, mem_data(RESET_PC));
        end
        @(negedge clk); #2;
        total++;
        if (if_valid !== 1'b1 || if_instr !== mem_data(RESET_PC)) begin
            bad++; $display("FAIL stall_hold1: got valid=%b instr=%h expected valid=1 instr=%h",
                            if_valid, if_instr, mem_data(RESET_PC));
        end
        @(negedge clk); #2;
        total++;
        if (imem_req !== 1'b0 || if_pc !== RESET_PC || if_instr !== mem_data(RESET_PC)) begin
            bad++; $display("FAIL stall_hold2: got req=%b pc=%h instr=%h expected req=0 pc=%h instr=%h",
                            imem_req, if_pc, if_instr, RESET_PC, mem_data(RESET_PC));
        end
        stall = 1'b0;
        @(negedge clk); #2;
        total++;
        if (if_instr !== 32'hDEAD_BEEF || if_pc !== DEAD_ADDR) begin
            bad++; $display("FAIL stall_release: got instr=%h pc=%h expected instr=deadbeef pc=%h", if_instr, if_pc, DEAD_ADDR);
        end
        total++;
        if (func !== 5'h0F || instruction_type !== 2'b11) begin
            bad++; $display("FAIL stall_fields: got func=%h type=%b expected func=0f type=11", func, instruction_type);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
            bad++; $display("FAIL stall_resume: got req=%b addr=%h expected req=1 addr=00000108", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] a;
        int          gap;
        do_reset();
        rsp_extra = 2;
        rsp_xor   = 32'hFFFF_0000;
        wait_accept(a, gap);
        rsp_extra = 0;
        rsp_xor   = '0;
        ex_equal = 1'b1; ex_zero = 1'b1; ex_target = 32'h40;
        exp_q.delete();
        @(negedge clk);
        clear_ex();
        #2;
        total++;
        if (flush !== 1'b1 || if_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL redir_flush: got flush=%b valid=%b req=%b expected flush=1 valid=0 req=0",
                            flush, if_valid, imem_req);
        end
        @(negedge clk); #2;
        total++;
        if (flush !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL redir_discard: got flush=%b req=%b expected flush=0 req=0", flush, imem_req);
        end
        @(negedge clk); #2;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            bad++; $display("FAIL redir_req: got req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr);
        end
        wait_if_valid("redir_ifpc", 32'h40);
    endtask

    task automatic test_geq_and_brinco();
        logic [31:0] a;
        int          gap;
        do_reset();
        wait_accept(a, gap);
        ex_geq = 1'b1; ex_neg = 1'b1; ex_equal = 1'b1; ex_target = 32'h80;
        @(negedge clk); #2;
        total++;
        if (flush !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h104) begin
            bad++; $display("FAIL geq_neg: got flush=%b req=%b addr=%h expected flush=0 req=1 addr=00000104",
                            flush, imem_req, imem_addr);
        end
        @(negedge clk);
        ex_brinco = 1'b1;
        stall     = 1'b1;
        exp_q.delete();
        @(negedge clk);
        clear_ex();
        stall = 1'b0;
        #2;
        total++;
        if (flush !== 1'b1 || if_valid !== 1'b0) begin
            bad++; $display("FAIL brinco_flush: got flush=%b valid=%b expected flush=1 valid=0", flush, if_valid);
        end
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            bad++; $display("FAIL brinco_req: got req=%b addr=%h expected req=1 addr=00000080", imem_req, imem_addr);
        end
        wait_if_valid("brinco_ifpc", 32'h80);
    endtask

    task automatic test_leq();
        logic [31:0] a;
        int          gap;
        do_reset();
        wait_accept(a, gap);
        ex_leq = 1'b1; ex_neg = 1'b1; ex_target = 32'h200;
        exp_q.delete();
        @(negedge clk);
        clear_ex();
        #2;
        total++;
        if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            bad++; $display("FAIL leq_taken: got flush=%b req=%b addr=%h expected flush=1 req=1 addr=00000200",
                            flush, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] a;
        int          gap;
        do_reset();
        rsp_extra = 2;
        rsp_xor   = 32'hFFFF_0000;
        wait_accept(a, gap);
        rsp_extra = 0;
        rsp_xor   = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #2;
        total++;
        if (if_valid !== 1'b0 || flush !== 1'b0 || imem_req !== 1'b0) begin
            bad++; $display("FAIL rstw_idle: got valid=%b flush=%b req=%b expected 0 0 0", if_valid, flush, imem_req);
        end
        @(negedge clk); #2;
        total++;
        if (imem_req !== 1'b0) begin bad++; $display("FAIL rstw_discard: got req=%b expected 0", imem_req); end
        @(negedge clk); #2;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            bad++; $display("FAIL rstw_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC);
        end
        wait_if_valid("rstw_ifpc", RESET_PC);
        total++;
        if (if_instr !== mem_data(RESET_PC)) begin
            bad++; $display("FAIL rstw_instr: got %h expected %h", if_instr, mem_data(RESET_PC));
        end
    endtask

    initial begin : main
        total = 0; bad = 0;
        rst = 1'b1; stall = 1'b0; hold_ready = 0; rsp_extra = 0; rsp_xor = '0;
        clear_ex();
        test_reset();
        test_sequential();
        test_ready_low();
        test_stall_skid();
        test_redirect_wait();
        test_geq_and_brinco();
        test_leq();
        test_reset_in_wait();
        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
